// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: ALU writeback has priority, colliding multiplier
// results are buffered and drained in idle ALU slots, with a starvation-forced drain.
module wb_port_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_BITS       = 5,
    parameter int unsigned MUL_FIFO_DEPTH = 2,
    parameter int unsigned MAX_WAIT       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid_in,
    input  logic                     alu_reg_write_in,
    input  logic [REG_BITS-1:0]      alu_rd_in,
    input  logic [XLEN-1:0]          alu_data_in,
    output logic                     alu_stall_out,
    input  logic                     mul_valid_in,
    input  logic [REG_BITS-1:0]      mul_rd_in,
    input  logic [XLEN-1:0]          mul_data_in,
    output logic                     mul_ready_out,
    output logic                     rf_we_out,
    output logic [REG_BITS-1:0]      rf_rd_out,
    output logic [XLEN-1:0]          rf_data_out,
    output logic [(2**REG_BITS)-1:0] mul_pending_out
);

    localparam int unsigned PTR_W  = $clog2(MUL_FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(MUL_FIFO_DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(MUL_FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] MAX_C   = WAIT_W'(MAX_WAIT);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    count_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [REG_BITS-1:0] fifo_rd   [MUL_FIFO_DEPTH];
    logic [XLEN-1:0]     fifo_data [MUL_FIFO_DEPTH];

    logic                fifo_empty;
    logic                alu_req, mul_req;
    logic                grant, push, pop;
    logic [REG_BITS-1:0] grant_rd;
    logic [XLEN-1:0]     grant_data;
    logic [PTR_W-1:0]    slot_off;

    assign fifo_empty    = (count_q == '0);
    assign mul_ready_out = ~reset & (count_q < DEPTH_C);
    assign alu_stall_out = (state_q == ST_FORCE);
    assign alu_req       = alu_valid_in & alu_reg_write_in & (alu_rd_in != '0);
    // rd==0 results are accepted (ready handshake) but never stored or written
    assign mul_req       = mul_valid_in & mul_ready_out & (mul_rd_in != '0);

    // NORMAL and FORCE share the drain/bypass path; FORCE only masks the ALU request
    always_comb begin
        grant      = 1'b0;
        grant_rd   = '0;
        grant_data = '0;
        push       = 1'b0;
        pop        = 1'b0;
        if (alu_req && state_q == ST_NORMAL) begin
            grant      = 1'b1;
            grant_rd   = alu_rd_in;
            grant_data = alu_data_in;
            push       = mul_req;
        end else if (!fifo_empty) begin
            grant      = 1'b1;
            grant_rd   = fifo_rd[rd_ptr_q];
            grant_data = fifo_data[rd_ptr_q];
            pop        = 1'b1;
            push       = mul_req;
        end else if (mul_req) begin
            grant      = 1'b1;
            grant_rd   = mul_rd_in;
            grant_data = mul_data_in;
        end
    end

    always_comb begin
        wait_d  = '0;
        state_d = ST_NORMAL;
        if (!fifo_empty && !pop && state_q == ST_NORMAL)
            wait_d = (wait_q == MAX_C) ? wait_q : wait_q + 1'b1;
        if (state_q == ST_NORMAL && wait_d == MAX_C)
            state_d = ST_FORCE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_NORMAL;
            wait_q      <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rf_we_out   <= 1'b0;
            rf_rd_out   <= '0;
            rf_data_out <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rf_we_out <= grant;
            if (grant) begin
                rf_rd_out   <= grant_rd;
                rf_data_out <= grant_data;
            end
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr_q]   <= mul_rd_in;
            fifo_data[wr_ptr_q] <= mul_data_in;
        end
    end

    // A slot is live when its distance from the read pointer is below the count
    always_comb begin
        mul_pending_out = '0;
        slot_off        = '0;
        for (int unsigned i = 0; i < MUL_FIFO_DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, slot_off} < count_q)
                mul_pending_out[fifo_rd[i]] = 1'b1;
        end
        mul_pending_out[0] = 1'b0;
    end

    a_mul_protocol: assert property (@(posedge clk) disable iff (reset)
        !(mul_valid_in && !mul_ready_out));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus queues expected writes, a negedge
// monitor pops and compares each register-file write.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid_in, alu_reg_write_in;
    logic [4:0]  alu_rd_in;
    logic [31:0] alu_data_in;
    logic        alu_stall_out;
    logic        mul_valid_in;
    logic [4:0]  mul_rd_in;
    logic [31:0] mul_data_in;
    logic        mul_ready_out;
    logic        rf_we_out;
    logic [4:0]  rf_rd_out;
    logic [31:0] rf_data_out;
    logic [31:0] mul_pending_out;

    int checks = 0;
    int fails  = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .XLEN(32),
        .REG_BITS(5),
        .MUL_FIFO_DEPTH(2),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .alu_valid_in(alu_valid_in),
        .alu_reg_write_in(alu_reg_write_in),
        .alu_rd_in(alu_rd_in),
        .alu_data_in(alu_data_in),
        .alu_stall_out(alu_stall_out),
        .mul_valid_in(mul_valid_in),
        .mul_rd_in(mul_rd_in),
        .mul_data_in(mul_data_in),
        .mul_ready_out(mul_ready_out),
        .rf_we_out(rf_we_out),
        .rf_rd_out(rf_rd_out),
        .rf_data_out(rf_data_out),
        .mul_pending_out(mul_pending_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    // Drive one cycle of inputs, return #1 after the edge that consumed them
    task automatic cyc(input logic av, input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        alu_valid_in     = av;
        alu_reg_write_in = aw;
        alu_rd_in        = ard;
        alu_data_in      = ad;
        mul_valid_in     = mv;
        mul_rd_in        = mrd;
        mul_data_in      = md;
        @(posedge clk);
        #1;
        alu_valid_in     = 1'b0;
        alu_reg_write_in = 1'b0;
        mul_valid_in     = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        cyc(1'b1, 1'b1, rd, d, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin : monitor
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (rf_we_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write",
                             rf_rd_out, rf_data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({rf_rd_out, rf_data_out} !== e) begin
                        fails++;
                        $display("FAIL rf_write: got rd=%0d data=%0h expected rd=%0d data=%0h",
                                 rf_rd_out, rf_data_out, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        reset            = 1'b1;
        alu_valid_in     = 1'b0;
        alu_reg_write_in = 1'b0;
        alu_rd_in        = '0;
        alu_data_in      = '0;
        mul_valid_in     = 1'b0;
        mul_rd_in        = '0;
        mul_data_in      = '0;
        #1;
        chk("ready_in_reset", 64'(mul_ready_out), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 64'(rf_we_out), 64'd0);
        chk("rst_rd", 64'(rf_rd_out), 64'd0);
        chk("rst_data", 64'(rf_data_out), 64'd0);
        chk("rst_stall", 64'(alu_stall_out), 64'd0);
        chk("rst_pending", 64'(mul_pending_out), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 64'(mul_ready_out), 64'd1);

        // Collision: ALU wins, multiplier result follows next cycle
        expect_wr(5, 32'h11);
        expect_wr(6, 32'h22);
        cyc(1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
        chk("col_we_n1", 64'(rf_we_out), 64'd1);
        chk("col_rd_n1", 64'(rf_rd_out), 64'd5);
        chk("col_pend_n1", 64'(mul_pending_out), 64'h40);
        idle();
        chk("col_rd_n2", 64'(rf_rd_out), 64'd6);
        chk("col_data_n2", 64'(rf_data_out), 64'h22);
        chk("col_pend_n2", 64'(mul_pending_out), 64'd0);
        idle();
        chk("col_we_n3", 64'(rf_we_out), 64'd0);

        // Bypass with empty FIFO
        expect_wr(7, 32'hAB);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAB);
        chk("byp_we", 64'(rf_we_out), 64'd1);
        chk("byp_rd", 64'(rf_rd_out), 64'd7);
        chk("byp_data", 64'(rf_data_out), 64'hAB);
        chk("byp_pending", 64'(mul_pending_out), 64'd0);
        idle();
        chk("byp_no_pop", 64'(rf_we_out), 64'd0);

        // Full: two buffered results block the third until a pop frees a slot
        expect_wr(1, 32'h101);
        expect_wr(2, 32'h102);
        expect_wr(3, 32'h103);
        expect_wr(10, 32'h201);
        expect_wr(11, 32'h202);
        expect_wr(12, 32'h203);
        cyc(1'b1, 1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'h201);
        chk("full_ready_c0", 64'(mul_ready_out), 64'd1);
        chk("full_pend_c0", 64'(mul_pending_out), 64'h400);
        cyc(1'b1, 1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'h202);
        chk("full_ready_c1", 64'(mul_ready_out), 64'd0);
        chk("full_pend_c1", 64'(mul_pending_out), 64'hC00);
        alu(5'd3, 32'h103);
        chk("full_ready_c2", 64'(mul_ready_out), 64'd0);
        chk("full_stall_c2", 64'(alu_stall_out), 64'd0);
        idle();
        chk("full_pop1_rd", 64'(rf_rd_out), 64'd10);
        chk("full_ready_c3", 64'(mul_ready_out), 64'd1);
        chk("full_pend_c3", 64'(mul_pending_out), 64'h800);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h203);
        chk("full_pop2_rd", 64'(rf_rd_out), 64'd11);
        chk("full_pend_c4", 64'(mul_pending_out), 64'h1000);
        idle();
        chk("full_pop3_rd", 64'(rf_rd_out), 64'd12);
        chk("full_pend_c5", 64'(mul_pending_out), 64'd0);
        idle();
        chk("full_we_end", 64'(rf_we_out), 64'd0);

        // Starvation: head waits 4 cycles, then one forced drain stalls the ALU
        expect_wr(1, 32'h401);
        expect_wr(2, 32'h402);
        expect_wr(3, 32'h403);
        expect_wr(4, 32'h404);
        expect_wr(5, 32'h405);
        expect_wr(9, 32'h99);
        expect_wr(6, 32'h406);
        cyc(1'b1, 1'b1, 5'd1, 32'h401, 1'b1, 5'd9, 32'h99);
        alu(5'd2, 32'h402);
        alu(5'd3, 32'h403);
        alu(5'd4, 32'h404);
        chk("starve_no_stall_yet", 64'(alu_stall_out), 64'd0);
        alu(5'd5, 32'h405);
        chk("starve_stall", 64'(alu_stall_out), 64'd1);
        chk("starve_pend", 64'(mul_pending_out), 64'h200);
        alu(5'd6, 32'h406);
        chk("starve_stall_clear", 64'(alu_stall_out), 64'd0);
        chk("starve_drain_rd", 64'(rf_rd_out), 64'd9);
        chk("starve_drain_data", 64'(rf_data_out), 64'h99);
        alu(5'd6, 32'h406);
        chk("starve_held_rd", 64'(rf_rd_out), 64'd6);
        idle();
        chk("starve_we_end", 64'(rf_we_out), 64'd0);

        // x0 filtering and non-writing ALU requests
        cyc(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        chk("x0_we", 64'(rf_we_out), 64'd0);
        chk("x0_pending", 64'(mul_pending_out), 64'd0);
        chk("x0_ready", 64'(mul_ready_out), 64'd1);
        cyc(1'b1, 1'b0, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        chk("nowrite_we", 64'(rf_we_out), 64'd0);
        idle();
        chk("x0_no_push", 64'(rf_we_out), 64'd0);

        // Reset while two results are buffered
        expect_wr(1, 32'h501);
        expect_wr(2, 32'h502);
        cyc(1'b1, 1'b1, 5'd1, 32'h501, 1'b1, 5'd20, 32'h601);
        cyc(1'b1, 1'b1, 5'd2, 32'h502, 1'b1, 5'd21, 32'h602);
        chk("rstd_pend_before", 64'(mul_pending_out), 64'h300000);
        chk("rstd_ready_before", 64'(mul_ready_out), 64'd0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        #1;
        chk("rstd_we_1", 64'(rf_we_out), 64'd0);
        chk("rstd_pending", 64'(mul_pending_out), 64'd0);
        chk("rstd_ready", 64'(mul_ready_out), 64'd1);
        chk("rstd_stall", 64'(alu_stall_out), 64'd0);
        idle();
        chk("rstd_we_2", 64'(rf_we_out), 64'd0);
        idle();
        chk("rstd_no_drain", 64'(rf_we_out), 64'd0);

        repeat (3) idle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order ALU/load writeback path and the multi-cycle multiplier pipeline.
- The ALU path has priority. Colliding multiplier results are buffered in a small FIFO and drained in idle ALU slots.
- A starvation counter forces a multiplier drain by stalling the ALU path.
- Sits between the writeback stage and the register file.

Parameters:
- XLEN, 32, datapath width.
- REG_BITS, 5, register index width.
- MUL_FIFO_DEPTH, 2, multiplier result buffer entries (power of 2, >=2).
- MAX_WAIT, 4, cycles a FIFO head may wait ungranted before forced drain (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alu_valid_in  in  1  ALU/load writeback request valid.
- alu_reg_write_in  in  1  request actually writes the register file.
- alu_rd_in  in  REG_BITS  ALU destination register.
- alu_data_in  in  XLEN  ALU/load/PC+4 result.
- alu_stall_out  out  1  upstream must hold the current ALU request.
- mul_valid_in  in  1  multiplier result valid.
- mul_rd_in  in  REG_BITS  multiplier destination register.
- mul_data_in  in  XLEN  multiplier result.
- mul_ready_out  out  1  arbiter can accept a multiplier result this cycle.
- rf_we_out  out  1  register-file write enable (registered).
- rf_rd_out  out  REG_BITS  register-file write index (registered).
- rf_data_out  out  XLEN  register-file write data (registered).
- mul_pending_out  out  2**REG_BITS  bitmask of destinations held in the FIFO (hazard/scoreboard use).

Behaviour:
- Reset:
  - FIFO empty; wait counter 0; state NORMAL.
  - rf_we_out=0, rf_rd_out=0, rf_data_out=0, alu_stall_out=0, mul_pending_out=0.
  - mul_ready_out = ~reset & (count < MUL_FIFO_DEPTH), so it is 0 during reset and 1 after.
- Request qualification:
  - ALU write request = alu_valid_in & alu_reg_write_in & (alu_rd_in != 0).
  - A mul_valid_in with mul_rd_in == 0 is accepted and discarded: no push, no write.
- Grant is decided in cycle N and the rf_* registers update at the N->N+1 edge (1-cycle latency). When no grant occurs, rf_we_out=0 and rf_rd_out/rf_data_out hold their previous values.
- State NORMAL, priority order:
  1. ALU request: granted. A simultaneous multiplier result is pushed if it is accepted.
  2. No ALU request, FIFO non-empty: FIFO head granted and popped. A simultaneous multiplier result is pushed.
  3. No ALU request, FIFO empty, multiplier result valid: bypass, written directly with no push.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and the head is not granted.
  - Clears on any pop or while the FIFO is empty.
  - Saturates at MAX_WAIT.
- Transition NORMAL->FORCE: occurs when the counter equals MAX_WAIT at the clock edge.
- State FORCE:
  - alu_stall_out=1 (registered from the state).
  - The ALU request is ignored, and upstream holds it.
  - The FIFO head is granted and popped.
  - An incoming multiplier result is pushed if accepted.
  - Transition FORCE->NORMAL: unconditional after one cycle; the counter clears.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo MUL_FIFO_DEPTH and a separate count.
  - Full/ready: mul_ready_out deasserts when count == MUL_FIFO_DEPTH, even if a pop occurs in the same cycle; there is no simultaneous push-while-full.
  - Push and pop in the same cycle leaves count unchanged.
- mul_valid_in while mul_ready_out=0 is a protocol violation: the result is dropped, and a simulation assertion fires.
- mul_pending_out: a bit is set while any FIFO entry targets that register. It is recomputed combinationally from valid FIFO entries, and bit 0 is always 0.
- WAW ordering between a buffered multiplier result and a younger ALU write to the same register is prevented by the issue stage using mul_pending_out. The arbiter performs no check.
- Reset mid-operation: FIFO contents are lost, state returns to NORMAL, and no write is issued in the reset cycle or the cycle after.

Test Plan:
- Collision: ALU x5=0x11 and MUL x6=0x22 in cycle N -> rf writes x5=0x11 in N+1 and x6=0x22 in N+2; mul_pending_out bit 6 is set during N+1 only.
- Bypass: MUL x7=0xAB alone with the FIFO empty -> rf_we_out=1, x7=0xAB next cycle; the FIFO stays empty.
- Full: continuous ALU writes plus 3 MUL results with DEPTH=2 -> mul_ready_out=0 after 2 pushes; when ALU idles, pops occur in FIFO order.
- Starvation: continuous ALU writes and 1 buffered MUL x9=0x99, MAX_WAIT=4 -> after 4 waiting cycles, alu_stall_out=1 for one cycle and x9=0x99 is written; the held ALU request is written the following cycle.
- x0 filtering: ALU rd=0 and MUL rd=0 -> no rf write, no push, mul_pending_out=0.
- Reset mid-drain: FIFO holds 2 entries, reset asserted one cycle -> count=0, rf_we_out=0 for two cycles, mul_ready_out=1 after reset deasserts.
